fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the rv32i pipeline, including the IF/ID pipeline register. It holds the fetch PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake. It delivers `InstrD`/`PCD`/`PCPlus4D` to decode and obeys `stallF`/`flushF`/`stallD`/`flushD` from `hazard_unit`. It takes the branch/jump redirect (`PCSrcE`, `PCTargetE`) from execute.

## Interface
- `XLEN`, 32, data/address width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous active-high reset.
- `stallF`  in  1  hold fetch PC; issue no new request.
- `flushF`  in  1  discard in-flight or held fetch.
- `stallD`  in  1  hold IF/ID register.
- `flushD`  in  1  load bubble into IF/ID.
- `PCSrcE`  in  1  redirect request from execute.
- `PCTargetE`  in  XLEN  redirect address.
- `imem_req`  out  1  request valid.
- `imem_addr`  out  XLEN  request address (word aligned).
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid; arrives ≥1 cycle after gnt.
- `imem_rdata`  in  32  response instruction.
- `InstrD`  out  32  decode instruction.
- `PCD`  out  XLEN  PC of `InstrD`.
- `PCPlus4D`  out  XLEN  `PCD`+4.
- `validD`  out  1  `InstrD` is a real instruction, not a bubble.

## Operation
- Registers:
  - `PCF`: next address to request.
  - `pc_fly`: address of the outstanding request.
  - `kill`: outstanding response must be dropped.
  - `hold_instr`/`hold_pc`: one-entry buffer.
- At most one outstanding request.
- FSM `fetch_state_t`:
  - REQ: `imem_req`=!stallF && !kill-pending. `imem_addr`=`PCF`.
    - On gnt: `pc_fly`<=`PCF`, `PCF`<=`PCF`+4, go to WAIT.
  - WAIT: wait for rvalid.
    - `kill`=1: drop the response, clear `kill`, go to REQ.
    - Else, if !stallD: write IF/ID, go to REQ.
    - Else: write the hold buffer, go to HOLD.
  - HOLD: when !stallD, move the buffer into IF/ID and go to REQ.
- Redirect (`PCSrcE`=1) has priority over `stallF`:
  - `PCF`<=`PCTargetE`.
  - WAIT: set `kill`.
  - HOLD: discard the buffer, go to REQ.
  - REQ with gnt in the same cycle: go to WAIT with `kill`=1; `PCF` still takes `PCTargetE`, not +4.
- `flushF`: same discard as redirect, but `PCF` is unchanged.
- IF/ID register, priority `flushD` > `stallD` > load:
  - `flushD`: `InstrD`=32'h0000_0013 (NOP), `validD`=0. PCs keep their old value.
  - Any cycle without a load (and without flush): `validD` keeps its value only under `stallD`; otherwise it goes to 0.
- Arithmetic: `PCF`+4 and `PCPlus4D` wrap modulo 2^XLEN. `PCTargetE[1:0]` is ignored (forced 0).

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `PCF`=`RESET_PC`, state=REQ, `kill`=0.
  - `InstrD`=NOP, `validD`=0, `PCD`=0, `PCPlus4D`=0.
- First request is in the cycle after `rst` deasserts.
- Zero-wait memory (gnt with req, rvalid next cycle):
  - REQ c0, WAIT c1, IF/ID valid c2.
  - Throughput is 1 instruction per 2 cycles.
- Redirect in cycle c: request to `PCTargetE` is no earlier than c+1. If a request is outstanding, it follows the killed response.
- `rst` mid-operation returns to reset values next edge. A response arriving after reset is ignored: REQ does not consume rvalid.
- Simultaneous rvalid and redirect in WAIT: the response is dropped.
- Simultaneous rvalid and `flushD`: the response is dropped and IF/ID gets the bubble.

## Structure
- `rv32i_pkg` additions:
  - `fetch_state_t` (REQ, WAIT, HOLD).
  - `NOP_INSTR` = 32'h0000_0013.
  - `RESET_PC_DEFAULT`.
- Sub-module `if_id_reg`: IF/ID register with flush/stall priority and bubble insertion.
- The FSM, PC and hold buffer stay in `fetch_stage`.

## Test plan
- Reset release, zero-wait memory returning 0x00500093 for addr 0 → `imem_addr`=0 at c0; `InstrD`=0x00500093, `PCD`=0, `PCPlus4D`=4, `validD`=1 at c2; next `imem_addr`=4.
- gnt delayed 3 cycles → `imem_req` and `imem_addr` stable until gnt; exactly one response consumed.
- `stallD`=1 for 4 cycles while rvalid arrives → data in HOLD, IF/ID unchanged. On release, IF/ID takes the held instruction with the correct PC; no instruction lost or duplicated.
- `PCSrcE`=1, `PCTargetE`=0x100 in WAIT → stale response dropped; next `imem_addr`=0x100; `PCD`=0x100 on delivery.
- `PCSrcE` together with gnt in REQ at PC 0x8 → the response for 0x8 is killed; following request is 0x100, not 0xC.
- `flushD` with `stallD` both high → `InstrD`=NOP, `validD`=0. `PCF` wrap at 0xFFFFFFFC → next request 0x0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared rv32i pipeline types and constants used by the fetch stage and IF/ID register.
// Pure declarations: no timing or flow control of its own.
package rv32i_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: bubble insertion with flush > stall > load priority; loads in 1 cycle.
// Stall holds every field; a cycle with neither stall nor load leaves a bubble (valid drops).
module if_id_reg
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            load_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush_i) begin
            // PCs are left alone on a flush; only the instruction becomes a NOP bubble.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            if (load_i) begin
                instr_d = instr_i;
                pc_d    = pc_i;
                pc4_d   = pc_i + XLEN'(4);
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rv32i fetch stage: one outstanding imem request, 2 cycles request-to-IF/ID with zero-wait memory.
// stallF blocks new requests; a response arriving under stallD parks in a one-entry hold buffer.
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            flushF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            validD
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] pc_fly_q, pc_fly_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]     hold_instr_q, hold_instr_d;
    logic            kill_q, kill_d;

    logic [XLEN-1:0] target;
    logic            discard;
    logic            req;
    logic            accepted;
    logic            load_ifid;
    logic [31:0]     ifid_instr;
    logic [XLEN-1:0] ifid_pc;

    assign target   = PCTargetE & ~{{(XLEN-2){1'b0}}, 2'b11};
    assign discard  = PCSrcE | flushF;
    assign req      = (state_q == REQ) && !stallF && !kill_q && !rst;
    assign accepted = req && imem_gnt;

    assign imem_req  = req;
    assign imem_addr = pcf_q;

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        pc_fly_d     = pc_fly_q;
        kill_d       = kill_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        load_ifid    = 1'b0;
        ifid_instr   = imem_rdata;
        ifid_pc      = pc_fly_q;

        if (PCSrcE) begin
            pcf_d = target;
        end

        case (state_q)
            REQ: begin
                if (accepted) begin
                    pc_fly_d = pcf_q;
                    state_d  = WAIT;
                    // A request granted alongside a discard is already stale; flushF refetches the same PC.
                    if (discard) begin
                        kill_d = 1'b1;
                    end else begin
                        pcf_d = pcf_q + XLEN'(4);
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                    kill_d  = 1'b0;
                    if (!kill_q && !discard && !flushD) begin
                        if (!stallD) begin
                            load_ifid = 1'b1;
                        end else begin
                            hold_instr_d = imem_rdata;
                            hold_pc_d    = pc_fly_q;
                            state_d      = HOLD;
                        end
                    end
                end else if (discard) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (discard || flushD) begin
                    state_d = REQ;
                end else if (!stallD) begin
                    load_ifid  = 1'b1;
                    ifid_instr = hold_instr_q;
                    ifid_pc    = hold_pc_q;
                    state_d    = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= REQ;
            pcf_q        <= RESET_PC;
            pc_fly_q     <= RESET_PC;
            kill_q       <= 1'b0;
            hold_pc_q    <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            pc_fly_q     <= pc_fly_d;
            kill_q       <= kill_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flushD),
        .stall_i    (stallD),
        .load_i     (load_ifid),
        .instr_i    (ifid_instr),
        .pc_i       (ifid_pc),
        .instr_o    (InstrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (validD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scripted imem responder, program-order expectation queue, decoupled consumer/monitor.
module tb_fetch_stage;
    import rv32i_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stallF, flushF, stallD, flushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        validD;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stallF     (stallF),
        .flushF     (flushF),
        .stallD     (stallD),
        .flushD     (flushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .validD     (validD)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_consumed = 0;
    bit mon_en = 1'b1;

    // Instruction memory contents: address 0 holds addi x1,x0,5; others are a bijective hash of the address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: program-order PCs that decode should consume next.
    logic [31:0] exp_q[$];
    logic [31:0] exp_next;

    task automatic topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
        end
    endtask

    task automatic model_restart(input logic [31:0] pc);
        exp_q.delete();
        exp_next = pc & 32'hFFFF_FFFC;
        topup();
    endtask

    // Memory responder
    bit mem_rand = 1'b0;
    int gdly_cfg = 0, rlat_cfg = 0, gdly_lim = 0;
    bit pend = 1'b0;
    int cnt = 0, gwait = 0;
    logic [31:0] paddr = '0;

    task automatic set_mem(input bit rnd, input int g, input int r);
        mem_rand = rnd; gdly_cfg = g; rlat_cfg = r;
        gdly_lim = g; gwait = 0; pend = 1'b0; cnt = 0;
    endtask

    initial begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_gnt = 1'b0;
            imem_rvalid = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = instr_of(paddr);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (imem_req) begin
                if (gwait >= gdly_lim) begin
                    imem_gnt = 1'b1;
                    pend  = 1'b1;
                    paddr = imem_addr;
                    cnt   = mem_rand ? int'($urandom_range(0, 2)) : rlat_cfg;
                    gwait = 0;
                    gdly_lim = mem_rand ? int'($urandom_range(0, 3)) : gdly_cfg;
                end else begin
                    gwait++;
                end
            end
        end
    end

    // Monitor: decode consumes InstrD whenever it is valid and not stalled or flushed.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && !rst && validD && !stallD && !flushD) begin
                n_consumed++;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_delivery: got PCD %h, expected none", PCD);
                end else begin
                    e = exp_q.pop_front();
                    check("PCD", PCD, e);
                    check("InstrD", InstrD, instr_of(e));
                    check("PCPlus4D", PCPlus4D, e + 32'd4);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        topup();
    endtask

    task automatic do_reset(input bit chk);
        rst = 1'b1; stallF = 1'b0; flushF = 1'b0; stallD = 1'b0; flushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = '0;
        step();
        step();
        if (chk) begin
            check("rst_imem_req", 32'(imem_req), 32'd0);
            check("rst_imem_addr", imem_addr, TB_RESET_PC);
            check("rst_InstrD", InstrD, NOP_INSTR);
            check("rst_validD", 32'(validD), 32'd0);
            check("rst_PCD", PCD, 32'd0);
            check("rst_PCPlus4D", PCPlus4D, 32'd0);
        end
        rst = 1'b0;
        model_restart(TB_RESET_PC);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        PCSrcE = 1'b1; PCTargetE = tgt; flushD = 1'b1;
        model_restart(tgt);
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp_addr);
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) check(name, imem_addr, exp_addr);
        else begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got no request within 30 cycles, expected addr %h", name, exp_addr);
        end
    endtask

    initial begin
        logic [31:0] tgt;
        int r;
        rst = 1'b1;

        // Zero-wait fetch from reset, then a 4-cycle stallD while the next response lands.
        do_reset(1'b1);
        @(negedge clk);
        check("c0_req", 32'(imem_req), 32'd1);
        check("c0_addr", imem_addr, 32'h0);
        step();
        step();
        stallD = 1'b1;
        @(negedge clk);
        check("c2_validD", 32'(validD), 32'd1);
        check("c2_InstrD", InstrD, 32'h0050_0093);
        check("c2_PCD", PCD, 32'h0);
        check("c2_PCPlus4D", PCPlus4D, 32'h4);
        check("c2_next_addr", imem_addr, 32'h4);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            check("stall_PCD", PCD, 32'h0);
            check("stall_validD", 32'(validD), 32'd1);
            check("stall_no_req", 32'(imem_req), 32'd0);
        end
        step();
        stallD = 1'b0;
        repeat (12) step();

        // Grant delayed by 3 cycles: request held stable until accepted.
        do_reset(1'b0);
        set_mem(1'b0, 3, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("gdly_req", 32'(imem_req), 32'd1);
            check("gdly_addr", imem_addr, 32'h0);
            step();
        end
        @(negedge clk);
        check("gdly_wait_no_req", 32'(imem_req), 32'd0);
        repeat (30) step();

        // Redirect while waiting on a slow response.
        do_reset(1'b0);
        set_mem(1'b0, 0, 3);
        step();
        redirect(32'h0000_0103);
        step();
        PCSrcE = 1'b0; flushD = 1'b0;
        wait_req("redir_wait_addr", 32'h100);
        repeat (12) step();

        // Redirect in the same cycle as the grant for PC 0x8.
        do_reset(1'b0);
        set_mem(1'b0, 0, 0);
        repeat (4) step();
        redirect(32'h100);
        @(negedge clk);
        check("redir_gnt_addr", imem_addr, 32'h8);
        step();
        PCSrcE = 1'b0; flushD = 1'b0;
        wait_req("redir_gnt_next", 32'h100);
        repeat (12) step();

        // flushF on a granted request: response dropped, same PC refetched.
        do_reset(1'b0);
        flushF = 1'b1;
        step();
        flushF = 1'b0;
        step();
        @(negedge clk);
        check("flushF_refetch_req", 32'(imem_req), 32'd1);
        check("flushF_refetch_addr", imem_addr, 32'h0);
        check("flushF_no_valid", 32'(validD), 32'd0);

        // Fetch PC wrap at the top of the address space.
        step();
        redirect(32'hFFFF_FFFC);
        step();
        PCSrcE = 1'b0; flushD = 1'b0;
        wait_req("wrap_first", 32'hFFFF_FFFC);
        step();
        wait_req("wrap_next", 32'h0);
        repeat (12) step();

        // Randomized traffic with stalls, redirects and occasional mid-run reset.
        do_reset(1'b0);
        set_mem(1'b1, 0, 0);
        n_consumed = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            rst = 1'b0; PCSrcE = 1'b0; flushD = 1'b0;
            stallD = ($urandom_range(0, 3) == 0);
            stallF = ($urandom_range(0, 6) == 0);
            r = int'($urandom_range(0, 399));
            if (r < 10) begin
                tgt = $urandom;
                redirect(tgt);
            end else if (r == 10) begin
                rst = 1'b1;
                model_restart(TB_RESET_PC);
            end
        end
        step();
        rst = 1'b0; PCSrcE = 1'b0; flushD = 1'b0; stallD = 1'b0; stallF = 1'b0;
        repeat (20) step();
        check("progress", 32'(n_consumed >= 200), 32'd1);

        // flushD wins over stallD.
        mon_en = 1'b0;
        flushD = 1'b1; stallD = 1'b1;
        step();
        flushD = 1'b0;
        @(negedge clk);
        check("flushD_stall_InstrD", InstrD, NOP_INSTR);
        check("flushD_stall_validD", 32'(validD), 32'd0);
        stallD = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
